// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the multiplexed hex display scanner.
package hex_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned DISP_W     = NUM_DIGITS * NIBBLE_W;

    // Load handshake state: EMPTY accepts a word, PENDING waits for frame wrap.
    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } load_state_e;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: counts 0..SCAN_DIV-1 and flags the last count as a tick.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [15:0] LastCnt = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LastCnt);

    // Wrap to zero on the tick cycle, otherwise count up.
    always_comb begin
        cnt_d = tick_o ? 16'd0 : cnt_q + 16'd1;
    end

    // Prescaler register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit hex display scanner with a one-word shadow load handshake.
// The display word only changes at frame wrap so a frame never mixes two words.
// Optional leading-zero blanking is built when HEX_LZB_EN is defined.
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_valid,
    input  logic [DISP_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [NIBBLE_W-1:0] nibble,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic              blank
);

    logic              tick;
    logic              frame_wrap;
    logic [1:0]        idx_q, idx_d;
    logic [DISP_W-1:0] display_q, display_d;
    logic [DISP_W-1:0] shadow_q, shadow_d;
    load_state_e       state_q, state_d;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick_gen (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .tick_o (tick)
    );

    assign frame_wrap = tick && (idx_q == 2'd3);
    assign ld_ready   = (state_q == EMPTY);

    // Next-state: digit index, load FSM, shadow capture and frame-aligned commit.
    always_comb begin
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        state_d   = state_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        unique case (state_q)
            EMPTY: begin
                // A load taken on the wrap cycle waits for the following wrap.
                if (ld_valid) begin
                    shadow_d = ld_data;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (frame_wrap) begin
                    display_d = shadow_q;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q     <= 2'd0;
            state_q   <= EMPTY;
            shadow_q  <= '0;
            display_q <= '0;
        end else begin
            idx_q     <= idx_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
        end
    end

    assign nibble = display_q[{idx_q, 2'b00} +: NIBBLE_W];

`ifdef HEX_LZB_EN
    // Digit k is blanked when digits k..3 are all zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        unique case (idx_q)
            2'd0: blank = 1'b0;
            2'd1: blank = (display_q[15:4] == 12'h000);
            2'd2: blank = (display_q[15:8] == 8'h00);
            2'd3: blank = (display_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Active-low one-hot enable, all off while the digit is blanked.
    always_comb begin
        digit_sel = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed, table-driven bench for hex_scan_ctrl with SCAN_DIV=4 (16-clock frames).
module tb_hex_scan_ctrl;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        exp_ready;
        logic [15:0] exp_disp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [3:0]  nibble;
    logic [3:0]  digit_sel;
    logic        blank;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    hex_scan_ctrl #(
        .SCAN_DIV (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .nibble    (nibble),
        .digit_sel (digit_sel),
        .blank     (blank)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_blank(input logic [15:0] disp, input int idx);
`ifdef HEX_LZB_EN
        logic [15:0] upper;
        upper = disp >> (4 * idx);
        return (idx != 0) && (upper == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic add_run(input int n, input logic v, input logic [15:0] d,
                           input logic r, input logic [15:0] disp);
        vec_t e;
        e.valid = v; e.data = d; e.exp_ready = r; e.exp_disp = disp;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input logic r, input logic [15:0] disp,
                                 input int idx);
        logic       b;
        logic [3:0] sel;
        logic [3:0] nib;
        b   = exp_blank(disp, idx);
        sel = b ? 4'b1111 : ~(4'b0001 << idx);
        nib = disp[4*idx +: 4];
        check({tag, " ld_ready"}, {15'd0, ld_ready}, {15'd0, r});
        check({tag, " nibble"}, {12'd0, nibble}, {12'd0, nib});
        check({tag, " digit_sel"}, {12'd0, digit_sel}, {12'd0, sel});
        check({tag, " blank"}, {15'd0, blank}, {15'd0, b});
    endtask

    initial begin
        // Cycle numbers in comments: frame wrap is each cycle c with c%16 == 15.
        add_run(1,  1'b1, 16'h1A2F, 1'b1, 16'h0000); // c0: basic load accepted
        add_run(15, 1'b1, 16'h5555, 1'b0, 16'h0000); // c1-15: backpressure held
        add_run(1,  1'b1, 16'h5555, 1'b1, 16'h1A2F); // c16: 5555 accepted on return
        add_run(15, 1'b0, 16'h0000, 1'b0, 16'h1A2F); // c17-31: F,2,A,1 scanned
        add_run(15, 1'b0, 16'h0000, 1'b1, 16'h5555); // c32-46: idle, ready
        add_run(1,  1'b1, 16'h00C3, 1'b1, 16'h5555); // c47: load on wrap cycle
        add_run(16, 1'b0, 16'h0000, 1'b0, 16'h5555); // c48-63: display unchanged
        add_run(1,  1'b1, 16'h0070, 1'b1, 16'h00C3); // c64: 00C3 visible, load 0070
        add_run(15, 1'b0, 16'h0000, 1'b0, 16'h00C3); // c65-79
        add_run(1,  1'b1, 16'hBEEF, 1'b1, 16'h0070); // c80: 0070 visible, load BEEF
        add_run(4,  1'b0, 16'h0000, 1'b0, 16'h0070); // c81-84: BEEF pending

        Reset    = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        @(negedge Clk);
        check_outputs("reset", 1'b1, 16'h0000, 0);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ld_valid = vecs[i].valid;
            ld_data  = vecs[i].data;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_disp,
                          (i / 4) % 4);
            @(negedge Clk);
        end

        // Asynchronous reset mid-PENDING, while digit 1 of 0070 (a 7) is showing.
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        check("pre-reset nibble", {12'd0, nibble}, 16'h0007);
        #2 Reset = 1'b1;
        #1 check_outputs("async reset", 1'b1, 16'h0000, 0);
        @(negedge Clk);
        check_outputs("reset held", 1'b1, 16'h0000, 0);
        Reset = 1'b0;

        // BEEF must have been discarded: two full frames of zeros, ready throughout.
        for (int c = 0; c < 32; c++) begin
            check_outputs($sformatf("post-reset c%0d", c), 1'b1, 16'h0000, (c / 4) % 4);
            @(negedge Clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, gives the clocks per digit dwell; legal range is 2..65535.
REQ-002 Port Clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1 bit, is the asynchronous, active-high reset.
REQ-004 Port ld_valid, input, 1 bit, signals that the producer offers a new display word.
REQ-005 Port ld_data, input, 16 bits, carries the display word; bits [3:0] form digit 0 and bits [15:12] form digit 3.
REQ-006 Port ld_ready, output, 1 bit, shows that the block can accept a word this cycle.
REQ-007 Port nibble, output, 4 bits, is the current digit value and feeds the downstream 7-segment decoder.
REQ-008 Port digit_sel, output, 4 bits, is the active-low one-hot digit enable.
REQ-009 Port blank, output, 1 bit, is high when the current digit is suppressed.

Function
REQ-010 A load SHALL be accepted on a rising edge where ld_valid=1 and ld_ready=1; ld_data is captured into the shadow register.
- Producer holds ld_data stable while ld_valid=1 and ld_ready=0.
REQ-011 The load FSM SHALL have two states:
- EMPTY (ld_ready=1): an accepted load moves it to PENDING.
- PENDING (ld_ready=0): a frame wrap copies shadow into the display register and returns to EMPTY.
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; a tick is the cycle where prescaler = SCAN_DIV-1.
REQ-013 On each tick, digit index idx SHALL advance 0->1->2->3->0.
- Frame wrap is a tick with idx=3.
REQ-014 The display register SHALL change only at frame wrap, so no frame ever mixes two words.
REQ-015 A load accepted on the frame-wrap cycle itself SHALL NOT be committed on that edge; it commits at the next frame wrap.
REQ-016 Latency from load acceptance to the display register update SHALL be between 1 and 4*SCAN_DIV clocks.
REQ-017 Outputs SHALL be combinational from registers only:
- nibble = display[4*idx+3 : 4*idx]
- digit_sel = ~(4'b0001 << idx), unless blanked
REQ-018 When blank=1, digit_sel SHALL be 4'b1111 and nibble SHALL still show the raw digit value.
REQ-019 The prescaler and idx SHALL run freely regardless of handshake activity.

Reset
REQ-020 While Reset=1, the block SHALL hold:
- prescaler=0, idx=0, display=16'h0000, shadow=16'h0000
- FSM=EMPTY
REQ-021 While Reset=1, the outputs SHALL be ld_ready=1, nibble=4'h0, digit_sel=4'b1110, blank=0.
REQ-022 Reset asserted mid-PENDING SHALL discard the shadow word; that word is never displayed.

Configuration
REQ-023 With HEX_LZB_EN defined, leading-zero blanking SHALL be enabled:
- Digit k (k=1..3) is blanked when display digits k..3 are all zero.
- Digit 0 is never blanked.
REQ-024 Without HEX_LZB_EN, blank SHALL be constant 0 and no blanking logic SHALL be synthesised.

Structure
REQ-025 Package hex_disp_pkg SHALL hold:
- NUM_DIGITS=4, NIBBLE_W=4
- the load FSM enum type (EMPTY, PENDING)
REQ-026 Sub-module scan_tick_gen (prescaler plus tick output, parameter SCAN_DIV) SHALL be instantiated once.
REQ-027 The 7-segment decoding SHALL stay outside this block.

Verification (SCAN_DIV=4)
REQ-028 Basic load: after Reset, load 16'h1A2F in one cycle.
- ld_ready falls on the next cycle.
- After the next frame wrap, nibble reads F,2,A,1 with digit_sel 1110,1101,1011,0111, each held 4 clocks.
REQ-029 Backpressure: hold ld_valid=1 with 16'h5555 while PENDING.
- ld_ready=0 until the frame wrap.
- 16'h5555 is accepted on the first cycle ld_ready returns to 1.
REQ-030 Load on wrap: accept 16'h00C3 exactly on a frame-wrap cycle.
- The display is unchanged for the following frame.
- The display shows 16'h00C3 after the next wrap.
REQ-031 Reset mid-operation: assert Reset while PENDING with 16'hBEEF.
- Outputs return to their reset values immediately (asynchronous).
- 16'hBEEF never appears on nibble.
REQ-032 Blanking, HEX_LZB_EN defined: display 16'h0070.
- Digits 3 and 2 have blank=1, digit_sel=1111.
- Digits 1 and 0 are shown.
- Without the macro, display 16'h0000 gives blank=0 on all digits.
